// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: FSM states, default sizes and the
// burst-length rule used by the slave output port.
package serial_bus_pkg;

  localparam int WORD_SIZE_DEF  = 8;
  localparam int BURST_SIZE_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_OFFER = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  // A requested burst of zero words still transfers one word.
  function automatic int unsigned effective_len(input int unsigned raw);
    return (raw == 0) ? 1 : raw;
  endfunction

endpackage

// File: rtl/slave_out_buffer.sv
// One-entry holding register between the slave core and the serializer.
// Push only when empty, pop only when full; flush discards the entry.
module slave_out_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Occupancy flag: set on push, cleared on pop or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush || i_pop) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
    end
  end

  // Payload capture on push.
  // NOTE: the payload is deliberately not reset; it is only ever read while
  // r_valid is set, so resetting it would add reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/slave_out_port.sv
// Slave-side read-data serializer: collects a burst of words from the slave
// core, offers it with s_valid/m_ready, then streams it LSB-first with no
// gaps. Optional feature macro: SLAVE_OUT_UNDERRUN_EN (sticky underrun flag).
module slave_out_port
  import serial_bus_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int BURST_SIZE = BURST_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start,
  input  logic [BURST_SIZE-1:0] burst_size,
  input  logic [WORD_SIZE-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  m_ready,
  output logic                  s_valid,
  output logic                  tx_data,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  underrun
);

  localparam int                    BIT_W    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
  localparam logic [BURST_SIZE-1:0] ONE      = BURST_SIZE'(1);

  state_t                r_state;
  state_t                w_next;
  logic [BURST_SIZE-1:0] r_len;    // effective burst length L
  logic [BURST_SIZE-1:0] r_words;  // words accepted plus underrun slots
  logic [BURST_SIZE-1:0] r_sent;   // index of the word being shifted out
  logic [BIT_W-1:0]      r_bit;    // bit index within the current word
  logic [WORD_SIZE-1:0]  r_shift;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_word_end;
  logic                  w_last_word;
  logic                  w_room;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_slot_underrun;
  logic                  w_buf_valid;
  logic [WORD_SIZE-1:0]  w_buf_data;
  logic [BURST_SIZE-1:0] w_len;

  assign w_len           = BURST_SIZE'(effective_len(32'(burst_size)));
  assign w_accept        = din_valid && din_ready;
  assign w_word_end      = (r_state == ST_SEND) && (r_bit == LAST_BIT);
  assign w_last_word     = (r_sent == r_len - ONE);
  assign w_room          = !w_buf_valid && (r_words < r_len);
  assign w_flush         = (r_state == ST_IDLE) && tx_start;
  // A word arriving on a word boundary bypasses the buffer into the shifter.
  assign w_push          = w_accept && !w_word_end &&
                           ((r_state == ST_OFFER) || (r_state == ST_SEND));
  assign w_pop           = w_word_end && !w_last_word && w_buf_valid;
  assign w_slot_underrun = w_word_end && !w_last_word && !w_buf_valid && !w_accept;

  slave_out_buffer #(
    .WIDTH (WORD_SIZE)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (din),
    .i_pop   (w_pop),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    din_ready = 1'b0;
    s_valid   = 1'b0;
    tx_busy   = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (tx_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        din_ready = 1'b1;
        if (din_valid) w_next = ST_OFFER;
      end
      ST_OFFER: begin
        s_valid   = 1'b1;
        din_ready = w_room;
        if (m_ready) w_next = ST_SEND;
      end
      ST_SEND: begin
        din_ready = w_room;
        if (w_word_end && w_last_word) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Burst counters, shift register and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_words <= '0;
      r_sent  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_word_end && w_last_word;
      if (w_flush) begin
        r_len   <= w_len;
        r_words <= '0;
        r_sent  <= '0;
        r_bit   <= '0;
      end else begin
        if (w_accept || w_slot_underrun) begin
          r_words <= r_words + ONE;
        end
        if (r_state == ST_LOAD && w_accept) begin
          r_shift <= din;
        end else if (r_state == ST_SEND) begin
          if (w_word_end) begin
            r_bit <= '0;
            if (!w_last_word) begin
              r_sent <= r_sent + ONE;
              if (w_buf_valid)   r_shift <= w_buf_data;
              else if (w_accept) r_shift <= din;
              else               r_shift <= '0;
            end
          end else begin
            r_bit   <= r_bit + BIT_ONE;
            r_shift <= r_shift >> 1;
          end
        end
      end
    end
  end

  assign tx_data = (r_state == ST_SEND) ? r_shift[0] : 1'b0;
  assign tx_done = r_done;

`ifdef SLAVE_OUT_UNDERRUN_EN
  logic r_underrun;

  // Sticky underrun flag, cleared when a new burst is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_flush) begin
      r_underrun <= 1'b0;
    end else if (w_slot_underrun) begin
      r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_slave_out_port.sv
// Self-checking bench for slave_out_port: a driver issues bursts and pushes
// the expected serial bit stream into a scoreboard; a monitor pops and
// compares once it sees the s_valid/m_ready handshake.
module tb_slave_out_port;

  localparam int W = 8;
`ifdef SLAVE_OUT_UNDERRUN_EN
  localparam bit UNDER_ON = 1'b1;
`else
  localparam bit UNDER_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        tx_start;
  logic [14:0] burst_size;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        m_ready;
  logic        s_valid;
  logic        tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        underrun;

  slave_out_port dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .burst_size (burst_size),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .m_ready    (m_ready),
    .s_valid    (s_valid),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int bursts_issued = 0;
  int bursts_checked = 0;

  int         exp_len_q[$];
  bit         exp_bits_q[$];
  bit         exp_under_q[$];
  logic [7:0] wbuf[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input int bs);
    return (bs == 0) ? 1 : bs;
  endfunction

  // Reference: slots 0..n_real-1 carry wbuf LSB-first, the rest are zeros.
  task automatic expect_burst(input int len, input int n_real, input bit under);
    exp_len_q.push_back(len);
    exp_under_q.push_back(under);
    for (int j = 0; j < len; j++)
      for (int k = 0; k < W; k++)
        exp_bits_q.push_back((j < n_real) ? wbuf[j][k] : 1'b0);
    bursts_issued++;
  endtask

  // Monitor: on each handshake, compare the serial stream and the done pulse.
  initial begin
    int len;
    bit under;
    bit aborted;
    bit dummy;
    forever begin
      @(negedge clk);
      if (!rst && s_valid && m_ready) begin
        if (exp_len_q.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          len = exp_len_q.pop_front();
          under = exp_under_q.pop_front();
          aborted = 1'b0;
          for (int b = 0; b < len * W; b++) begin
            @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              for (int r = b; r < len * W; r++) dummy = exp_bits_q.pop_front();
              break;
            end
            check("tx_bit", tx_data, exp_bits_q.pop_front());
          end
          if (!aborted) begin
            @(negedge clk);
            check("tx_done_pulse", tx_done, 1);
            check("tx_busy_at_done", tx_busy, 0);
            check("underrun_at_done", underrun, under);
            @(negedge clk);
            check("tx_done_low_after", tx_done, 0);
            check("tx_data_idle", tx_data, 0);
          end
          bursts_checked++;
        end
      end
    end
  end

  task automatic wait_s_valid();
    bit found = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("s_valid_timeout", found, 1);
  endtask

  task automatic send_word(input logic [7:0] w);
    bit ok = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check("din_accept_timeout", ok, 1);
  endtask

  task automatic start(input int bs);
    burst_size = 15'(bs);
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("din_ready_after_start", din_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // m_ready driver; mdelay < 0 keeps m_ready high from the start.
  task automatic mready_proc(input int mdelay, input bit spur);
    wait_s_valid();
    if (mdelay >= 0) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < mdelay; i++) begin
        @(negedge clk);
        check("s_valid_held", s_valid, 1);
        @(posedge clk);
        #1;
      end
      m_ready = 1'b1;
    end
    @(posedge clk);
    if (spur) begin
      repeat (2) @(posedge clk);
      #1;
      burst_size = 15'd5;
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
    end
  endtask

  task automatic wait_burst_done();
    bit ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bursts_checked == bursts_issued) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int bs, input int max_gap, input int mdelay, input bit spur);
    int len;
    len = eff_len(bs);
    expect_burst(len, len, 1'b0);
    m_ready = (mdelay < 0);
    start(bs);
    fork
      begin
        for (int j = 0; j < len; j++) begin
          repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
          end
          send_word(wbuf[j]);
        end
      end
      mready_proc(mdelay, spur);
    join
    wait_burst_done();
  endtask

  initial begin
    #200000;
    check("global_watchdog", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b0;
    tx_start = 1'b0;
    burst_size = '0;
    din = '0;
    din_valid = 1'b0;
    m_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", din_ready, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_underrun", underrun, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // din_valid in IDLE is never accepted.
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_din_ready", din_ready, 0);
    @(posedge clk);
    #1 din_valid = 1'b0;

    // Single word 0xA5, master ready throughout.
    wbuf[0] = 8'hA5;
    run_burst(1, 0, -1, 1'b0);

    // Three back-to-back words.
    wbuf[0] = 8'h01; wbuf[1] = 8'h80; wbuf[2] = 8'hFF;
    run_burst(3, 0, -1, 1'b0);

    // Master stalls 5 cycles in OFFER, plus a tx_start while busy.
    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    run_burst(2, 0, 4, 1'b1);

    // Underrun: second word only shows up at H+12.
    wbuf[0] = 8'h5A;
    expect_burst(2, 1, UNDER_ON);
    m_ready = 1'b1;
    start(2);
    send_word(wbuf[0]);
    wait_s_valid();
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    din = 8'h77;
    din_valid = 1'b1;
    @(negedge clk);
    check("late_word_ready", din_ready, 0);
    wait_burst_done();
    check("underrun_sticky", underrun, UNDER_ON);
    check("idle_no_accept", din_ready, 0);
    din_valid = 1'b0;

    // Reset during bit 4 of word 0, then a clean single-word burst.
    wbuf[0] = 8'h96;
    expect_burst(1, 1, 1'b0);
    m_ready = 1'b1;
    start(1);
    send_word(wbuf[0]);
    wait_s_valid();
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_din_ready", din_ready, 0);
    check("midrst_s_valid", s_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_busy", tx_busy, 0);
    check("midrst_tx_done", tx_done, 0);
    check("midrst_underrun", underrun, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_burst_done();
    wbuf[0] = 8'h4B;
    run_burst(1, 0, -1, 1'b0);

    // burst_size of zero sends exactly one word.
    wbuf[0] = 8'hE1;
    run_burst(0, 0, -1, 1'b0);

    // Randomized bursts.
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 4; j++) wbuf[j] = 8'($urandom);
      run_burst(int'($urandom_range(0, 4)), 3, int'($urandom_range(0, 7)) - 1,
                1'($urandom_range(0, 1)));
    end

    check("scoreboard_drained", exp_bits_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
